i2c_master_arbiter: RTL and testbench

I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

---
 rtl/i2c_arb_if.sv | 33 +++
 rtl/i2c_master_arbiter.sv | 137 +++++++++++++
 tb/tb_i2c_master_arbiter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_arb_if.sv
// Requester/fsm_master signal bundle for i2c_master_arbiter.
// The master modport is the arbiter; the slave modport is the requester/fsm_master side.
interface i2c_arb_if #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_LEN = 7,
  parameter int DATA_LEN = 8
);
  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*ADDR_LEN-1:0] req_addr;
  logic [NUM_REQ-1:0]          req_rw;
  logic [NUM_REQ*DATA_LEN-1:0] req_data1;
  logic [NUM_REQ*DATA_LEN-1:0] req_data2;
  logic [NUM_REQ-1:0]          gnt;
  logic [NUM_REQ-1:0]          done;
  logic                        err;
  logic                        busy;
  logic                        m_start;
  logic [ADDR_LEN-1:0]         m_add_reg;
  logic                        m_R_W;
  logic [DATA_LEN-1:0]         m_data_1;
  logic [DATA_LEN-1:0]         m_data_2;
  logic                        m_free;

  modport master (
    input  req, req_addr, req_rw, req_data1, req_data2, m_free,
    output gnt, done, err, busy, m_start, m_add_reg, m_R_W, m_data_1, m_data_2
  );

  modport slave (
    output req, req_addr, req_rw, req_data1, req_data2, m_free,
    input  gnt, done, err, busy, m_start, m_add_reg, m_R_W, m_data_1, m_data_2
  );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one fsm_master among NUM_REQ requesters.
// Optional watchdog on the WAIT states enabled by defining I2C_ARB_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | no transfer; grant when a request is pending and the master is free
// LAUNCH    | one-cycle m_start pulse
// WAIT_BUSY | waiting for the master to report busy (m_free=0)
// WAIT_FREE | waiting for the master to finish (m_free=1)
// DONE      | done pulse to the winner, advance the round-robin pointer
module i2c_master_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_LEN       = 7,
  parameter int DATA_LEN       = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic      clk,
  input logic      rst,
  i2c_arb_if.master bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_FREE, DONE} state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       rr_ptr, winner, pick, idx;
  logic                found;
  logic [NUM_REQ-1:0]  gnt_r;
  logic [ADDR_LEN-1:0] add_r, sel_addr;
  logic                rw_r, sel_rw;
  logic [DATA_LEN-1:0] d1_r, d2_r, sel_d1, sel_d2;
  logic                timeout_hit;

  // First pending requester at or above rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_rw   = 1'b0;
    sel_d1   = '0;
    sel_d2   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == PW'(i)) begin
        sel_addr = bus.req_addr[i*ADDR_LEN +: ADDR_LEN];
        sel_rw   = bus.req_rw[i];
        sel_d1   = bus.req_data1[i*DATA_LEN +: DATA_LEN];
        sel_d2   = bus.req_data2[i*DATA_LEN +: DATA_LEN];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (found && bus.m_free) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (timeout_hit) state_nxt = DONE;
                 else if (!bus.m_free) state_nxt = WAIT_FREE;
      WAIT_FREE: if (timeout_hit || bus.m_free) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      winner <= '0;
      gnt_r  <= '0;
      add_r  <= '0;
      rw_r   <= 1'b0;
      d1_r   <= '0;
      d2_r   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && state_nxt == LAUNCH) begin
        winner <= pick;
        gnt_r  <= NUM_REQ'(1) << pick;
        add_r  <= sel_addr;
        rw_r   <= sel_rw;
        d1_r   <= sel_d1;
        d2_r   <= sel_d2;
      end
      if (state == DONE) begin
        gnt_r  <= '0;
        rr_ptr <= (winner == PW'(NUM_REQ-1)) ? '0 : winner + 1'b1;
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          timed_out;

  // Count hits TIMEOUT_CYCLES on the same edge the FSM enters DONE.
  always_ff @(posedge clk) begin
    if (rst)                                         to_cnt <= '0;
    else if (state == LAUNCH)                        to_cnt <= '0;
    else if (state == WAIT_BUSY || state == WAIT_FREE) to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = (state == WAIT_BUSY || state == WAIT_FREE) &&
                       (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst)                timed_out <= 1'b0;
    else if (state == DONE) timed_out <= 1'b0;
    else if (timeout_hit)   timed_out <= 1'b1;
  end

  assign bus.err = (state == DONE) && timed_out;
`else
  assign timeout_hit = 1'b0;
  assign bus.err     = 1'b0;
`endif

  assign bus.gnt       = gnt_r;
  assign bus.done      = (state == DONE) ? gnt_r : '0;
  assign bus.busy      = (state != IDLE);
  assign bus.m_start   = (state == LAUNCH);
  assign bus.m_add_reg = add_r;
  assign bus.m_R_W     = rw_r;
  assign bus.m_data_1  = d1_r;
  assign bus.m_data_2  = d2_r;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Self-checking bench for i2c_master_arbiter: directed steps plus randomized transfers
// against a round-robin reference model; the bench plays the fsm_master.
module tb_i2c_master_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   rr_m   = 0;

  logic [6:0] a  [4];
  logic [7:0] d1 [4];
  logic [7:0] d2 [4];
  logic [3:0] rw_v;

  i2c_arb_if #(.NUM_REQ(4), .ADDR_LEN(7), .DATA_LEN(8)) bus ();

  i2c_master_arbiter #(
    .NUM_REQ(4), .ADDR_LEN(7), .DATA_LEN(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first set bit scanning upward from rr with wrap.
  function automatic int exp_winner(input logic [3:0] r, input int rr);
    for (int k = 0; k < 4; k++)
      if (r[(rr + k) % 4]) return (rr + k) % 4;
    return -1;
  endfunction

  task automatic pack_payload();
    bus.req_addr  = {a[3], a[2], a[1], a[0]};
    bus.req_data1 = {d1[3], d1[2], d1[1], d1[0]};
    bus.req_data2 = {d2[3], d2[2], d2[1], d2[0]};
    bus.req_rw    = rw_v;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < 4; i++) begin
      a[i]  = 7'($urandom);
      d1[i] = 8'($urandom);
      d2[i] = 8'($urandom);
    end
    rw_v = 4'($urandom);
    pack_payload();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left with the DUT in IDLE, sampled 1 time unit after an edge.
  task automatic run_xfer(input logic [3:0] r, input int hold, input bit drop);
    int w;
    logic [3:0] oh;
    logic [6:0] ea;
    logic       erw;
    logic [7:0] ed1, ed2;
    pack_payload();
    bus.req = r;
    w   = exp_winner(r, rr_m);
    oh  = 4'(1) << w;
    ea  = a[w];
    erw = rw_v[w];
    ed1 = d1[w];
    ed2 = d2[w];
    tick();
    chk("gnt_launch", 32'(bus.gnt), 32'(oh));
    chk("m_start_launch", 32'(bus.m_start), 32'd1);
    chk("busy_launch", 32'(bus.busy), 32'd1);
    chk("m_add_reg_launch", 32'(bus.m_add_reg), 32'(ea));
    chk("m_R_W_launch", 32'(bus.m_R_W), 32'(erw));
    chk("m_data_1_launch", 32'(bus.m_data_1), 32'(ed1));
    chk("m_data_2_launch", 32'(bus.m_data_2), 32'(ed2));
    tick();
    chk("m_start_one_cycle", 32'(bus.m_start), 32'd0);
    bus.m_free = 1'b0;
    if (drop) bus.req = bus.req & ~oh;
    rand_payload();
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("done_early", 32'(bus.done), 32'd0);
      chk("m_add_reg_hold", 32'(bus.m_add_reg), 32'(ea));
      rand_payload();
    end
    bus.m_free = 1'b1;
    tick();
    chk("done_pulse", 32'(bus.done), 32'(oh));
    chk("err_normal", 32'(bus.err), 32'd0);
    chk("gnt_at_done", 32'(bus.gnt), 32'(oh));
    chk("m_add_reg_done", 32'(bus.m_add_reg), 32'(ea));
    chk("m_R_W_done", 32'(bus.m_R_W), 32'(erw));
    chk("m_data_1_done", 32'(bus.m_data_1), 32'(ed1));
    chk("m_data_2_done", 32'(bus.m_data_2), 32'(ed2));
    tick();
    chk("done_cleared", 32'(bus.done), 32'd0);
    chk("gnt_cleared", 32'(bus.gnt), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    rr_m = (w + 1) % 4;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = 4'b1111;
    bus.m_free = 1'b1;
    tick();
    tick();
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_m_start", 32'(bus.m_start), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_m_add_reg", 32'(bus.m_add_reg), 32'd0);
    chk("rst_m_data_1", 32'(bus.m_data_1), 32'd0);
    rst = 1'b0;
    rr_m = 0;
  endtask

  initial begin
    int w;
    logic [3:0] oh;
    bus.req    = '0;
    bus.m_free = 1'b1;
    rand_payload();

    do_reset();

    // Single request with a fixed payload, then wrap-around from pointer 3.
    rand_payload();
    a[2] = 7'b1010110; rw_v[2] = 1'b1; d1[2] = 8'hab; d2[2] = 8'hab;
    run_xfer(4'b0100, 2, 1'b0);
    chk("rr_after_req2", 32'(exp_winner(4'b0011, rr_m)), 32'd0);
    rand_payload();
    run_xfer(4'b0011, 1, 1'b0);

    // Fairness from reset with all requesters held.
    do_reset();
    for (int t = 0; t < 5; t++) begin
      chk("fair_order", 32'(exp_winner(4'b1111, rr_m)), 32'(t % 4));
      rand_payload();
      run_xfer(4'b1111, 1, 1'b0);
    end

    // Randomized request patterns, busy lengths and early request drops.
    for (int t = 0; t < 24; t++) begin
      rand_payload();
      run_xfer(4'($urandom_range(1, 15)), int'($urandom_range(1, 5)), 1'($urandom));
    end

    // Master busy while idle: nothing may be granted.
    bus.m_free = 1'b0;
    bus.req = 4'b1111;
    repeat (5) begin
      tick();
      chk("no_gnt_master_busy", 32'(bus.gnt), 32'd0);
      chk("idle_master_busy", 32'(bus.busy), 32'd0);
    end
    bus.m_free = 1'b1;
    rand_payload();
    run_xfer(4'b1111, 2, 1'b0);

    // Reset in the middle of a transfer abandons it silently.
    rand_payload();
    bus.req = 4'b1000;
    tick();
    tick();
    bus.m_free = 1'b0;
    tick();
    rst = 1'b1;
    bus.req = 4'b0000;
    tick();
    rst = 1'b0;
    rr_m = 0;
    chk("midrst_gnt", 32'(bus.gnt), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    bus.m_free = 1'b1;
    repeat (3) begin
      tick();
      chk("midrst_no_done", 32'(bus.done), 32'd0);
    end
    rand_payload();
    run_xfer(4'b1111, 1, 1'b0);

    // Master never frees up after start.
    rand_payload();
    bus.req = 4'b0010;
    w  = exp_winner(4'b0010, rr_m);
    oh = 4'(1) << w;
    tick();
    chk("to_gnt", 32'(bus.gnt), 32'(oh));
    tick();
    bus.m_free = 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("to_done", 32'(bus.done), (k == 16) ? 32'(oh) : 32'd0);
      chk("to_err", 32'(bus.err), (k == 16) ? 32'd1 : 32'd0);
    end
    tick();
    chk("to_done_cleared", 32'(bus.done), 32'd0);
    chk("to_err_cleared", 32'(bus.err), 32'd0);
    chk("to_gnt_cleared", 32'(bus.gnt), 32'd0);
    rr_m = (w + 1) % 4;
    bus.req = 4'b0000;
    bus.m_free = 1'b1;
    tick();
    rand_payload();
    run_xfer(4'b1111, 1, 1'b0);
`else
    repeat (40) begin
      tick();
      chk("hang_busy", 32'(bus.busy), 32'd1);
      chk("hang_err", 32'(bus.err), 32'd0);
      chk("hang_done", 32'(bus.done), 32'd0);
    end
    do_reset();
    bus.req = 4'b0000;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
